// File: rtl/axis_hash_check_pkg.sv
// rtl/axis_hash_check_pkg.sv - shared constants for the hash-check frame engine
package axis_hash_check_pkg;

    localparam int NUMBER_OF_HASH_WORDS = 8;
    localparam int WORD_W               = 32;

    localparam logic [1:0] S_RECV    = 2'd0;
    localparam logic [1:0] S_COMPARE = 2'd1;
    localparam logic [1:0] S_SEND    = 2'd2;

    localparam int ST_HIT     = 0;
    localparam int ST_SHORT   = 1;
    localparam int ST_NOTLAST = 2;

    function automatic logic [WORD_W-1:0] pack_status(input logic hit,
                                                      input logic short_f,
                                                      input logic notlast);
        logic [WORD_W-1:0] s;
        s             = '0;
        s[ST_HIT]     = hit;
        s[ST_SHORT]   = short_f;
        s[ST_NOTLAST] = notlast;
        return s;
    endfunction

endpackage

// File: rtl/hash_cmp_serial.sv
// rtl/hash_cmp_serial.sv - word-serial digest <= target comparator, MS word first
module hash_cmp_serial
    import axis_hash_check_pkg::*;
#(
    parameter int NW = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [NW-1:0][WORD_W-1:0]    digest,
    input  logic [NW-1:0][WORD_W-1:0]    target,
    output logic                         done,
    output logic                         hit
);

    localparam int IW = $clog2(NW);

    logic              busy_q;
    logic [IW-1:0]     idx_q;
    logic [IW-1:0]     cur;
    logic              active;
    logic [WORD_W-1:0] dw;
    logic [WORD_W-1:0] tw;

    // The start cycle already examines the top word, so an early mismatch costs one cycle.
    assign cur    = start ? IW'(NW - 1) : idx_q;
    assign active = start || busy_q;
    assign dw     = digest[cur];
    assign tw     = target[cur];
    assign done   = active && ((dw != tw) || (cur == '0));
    assign hit    = active && (dw <= tw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            idx_q  <= '0;
        end else if (active && !done) begin
            busy_q <= 1'b1;
            idx_q  <= cur - IW'(1);
        end else begin
            busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_hash_check.sv
// rtl/axis_hash_check.sv - collects a digest frame, compares against target, reports status and count
module axis_hash_check
    import axis_hash_check_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int NUMBER_OF_HASH_WORDS = axis_hash_check_pkg::NUMBER_OF_HASH_WORDS
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_aresetn,
    input  logic [NUMBER_OF_HASH_WORDS*32-1:0]  target,
    output logic                                s00_axis_tready,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    input  logic                                s00_axis_tlast,
    input  logic                                s00_axis_tvalid,
    output logic                                m00_axis_tvalid,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                m00_axis_tlast,
    input  logic                                m00_axis_tready,
    output logic                                hit_pulse
);

    localparam int            IW       = $clog2(NUMBER_OF_HASH_WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUMBER_OF_HASH_WORDS - 1);

    logic [1:0]                                    state;
    logic [IW-1:0]                                 wr_idx;
    logic [NUMBER_OF_HASH_WORDS-1:0][WORD_W-1:0]   digest_q;
    logic [NUMBER_OF_HASH_WORDS-1:0][WORD_W-1:0]   target_q;
    logic                                          short_q;
    logic                                          notlast_q;
    logic [WORD_W-1:0]                             digest_cnt;
    logic                                          s_ready_q;
    logic                                          cmp_start_q;
    logic                                          beat_ok;
    logic                                          frame_end;
    logic                                          cmp_start;
    logic                                          cmp_done;
    logic                                          cmp_hit;
    logic                                          final_hit;
    logic                                          unused_tstrb;

    assign unused_tstrb    = &{1'b0, s00_axis_tstrb};
    assign s00_axis_tready = s_ready_q;
    assign m00_axis_tstrb  = '1;
    assign beat_ok         = s00_axis_tvalid && s_ready_q;
    assign frame_end       = beat_ok && (s00_axis_tlast || (wr_idx == LAST_IDX));
    assign cmp_start       = cmp_start_q && !short_q;
    assign final_hit       = !short_q && cmp_hit;

    // Digest buffer and frame target snapshot; no reset needed, written only on accepted beats.
    always_ff @(posedge s00_axis_aclk) begin
        if (beat_ok) begin
            digest_q[wr_idx] <= s00_axis_tdata;
            if (wr_idx == '0) begin
                target_q <= target;
            end
        end
    end

    hash_cmp_serial #(
        .NW (NUMBER_OF_HASH_WORDS)
    ) u_cmp (
        .clk    (s00_axis_aclk),
        .rst_n  (s00_axis_aresetn),
        .start  (cmp_start),
        .digest (digest_q),
        .target (target_q),
        .done   (cmp_done),
        .hit    (cmp_hit)
    );

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state           <= S_RECV;
            wr_idx          <= '0;
            short_q         <= 1'b0;
            notlast_q       <= 1'b0;
            digest_cnt      <= '0;
            s_ready_q       <= 1'b0;
            cmp_start_q     <= 1'b0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tlast  <= 1'b0;
            hit_pulse       <= 1'b0;
        end else begin
            hit_pulse   <= 1'b0;
            cmp_start_q <= 1'b0;
            case (state)
                S_RECV: begin
                    s_ready_q <= 1'b1;
                    if (frame_end) begin
                        state       <= S_COMPARE;
                        wr_idx      <= '0;
                        short_q     <= s00_axis_tlast && (wr_idx != LAST_IDX);
                        notlast_q   <= !s00_axis_tlast;
                        s_ready_q   <= 1'b0;
                        cmp_start_q <= 1'b1;
                    end else if (beat_ok) begin
                        wr_idx <= wr_idx + IW'(1);
                    end
                end
                S_COMPARE: begin
                    if (short_q || cmp_done) begin
                        state           <= S_SEND;
                        digest_cnt      <= digest_cnt + 32'd1;
                        hit_pulse       <= final_hit;
                        m00_axis_tvalid <= 1'b1;
                        m00_axis_tdata  <= pack_status(final_hit, short_q, notlast_q);
                        m00_axis_tlast  <= 1'b0;
                    end
                end
                S_SEND: begin
                    // tlast doubles as the beat index: low on the status beat, high on the count beat.
                    if (m00_axis_tvalid && m00_axis_tready) begin
                        if (!m00_axis_tlast) begin
                            m00_axis_tdata <= digest_cnt;
                            m00_axis_tlast <= 1'b1;
                        end else begin
                            state           <= S_RECV;
                            m00_axis_tvalid <= 1'b0;
                            m00_axis_tlast  <= 1'b0;
                            m00_axis_tdata  <= '0;
                            short_q         <= 1'b0;
                            notlast_q       <= 1'b0;
                            s_ready_q       <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= S_RECV;
                    s_ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_hash_check.sv
// tb/tb_axis_hash_check.sv - directed vector bench for axis_hash_check
module tb_axis_hash_check;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] target;
    logic         s_tready;
    logic [31:0]  s_tdata;
    logic [3:0]   s_tstrb;
    logic         s_tlast;
    logic         s_tvalid;
    logic         m_tvalid;
    logic [31:0]  m_tdata;
    logic [3:0]   m_tstrb;
    logic         m_tlast;
    logic         m_tready;
    logic         hit_pulse;

    int chk = 0;
    int err = 0;
    int pulse_cnt = 0;

    always #5 clk = ~clk;

    axis_hash_check dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .target           (target),
        .s00_axis_tready  (s_tready),
        .s00_axis_tdata   (s_tdata),
        .s00_axis_tstrb   (s_tstrb),
        .s00_axis_tlast   (s_tlast),
        .s00_axis_tvalid  (s_tvalid),
        .m00_axis_tvalid  (m_tvalid),
        .m00_axis_tdata   (m_tdata),
        .m00_axis_tstrb   (m_tstrb),
        .m00_axis_tlast   (m_tlast),
        .m00_axis_tready  (m_tready),
        .hit_pulse        (hit_pulse)
    );

    always @(negedge clk) if (hit_pulse === 1'b1) pulse_cnt++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1);
    end

    typedef struct {
        logic [255:0] dig;
        logic [255:0] tgt;
        int           nw;
        logic         tl;
        logic [31:0]  st;
        int           cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic put_beat(input logic [31:0] d, input logic l);
        int t = 0;
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        while (s_tready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("s_tready_timeout", 32'(s_tready), 32'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Target is flipped right after the first beat so a frame that re-samples it gets a different result.
    task automatic send_frame(input logic [255:0] dig, input logic [255:0] tgt,
                              input int nw, input logic tl);
        target = tgt;
        for (int i = 0; i < nw; i++) begin
            put_beat(dig[i*32 +: 32], tl && (i == nw - 1));
            if (i == 0) target = ~tgt;
        end
    endtask

    task automatic check_out(input string nm, input logic [31:0] st, input logic [31:0] cnt,
                             input int cyc, input int pulses, input int hold);
        int   n  = 0;
        int   p0 = pulse_cnt;
        logic ok;
        m_tready = (hold == 0);
        @(negedge clk);
        check({nm, "_s_tready_busy"}, 32'(s_tready), 32'd0);
        while (m_tvalid !== 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        check({nm, "_compare_cycles"}, 32'(n), 32'(cyc));
        check({nm, "_status"}, m_tdata, st);
        check({nm, "_status_tlast"}, 32'(m_tlast), 32'd0);
        if (hold > 0) begin
            ok = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                ok = ok && m_tvalid === 1'b1 && m_tdata === st && m_tlast === 1'b0 && s_tready === 1'b0;
            end
            check({nm, "_hold_stable"}, 32'(ok), 32'd1);
            m_tready = 1'b1;
        end
        @(negedge clk);
        check({nm, "_cnt_tvalid"}, 32'(m_tvalid), 32'd1);
        check({nm, "_count"}, m_tdata, cnt);
        check({nm, "_cnt_tlast"}, 32'(m_tlast), 32'd1);
        @(negedge clk);
        check({nm, "_idle_tvalid"}, 32'(m_tvalid), 32'd0);
        check({nm, "_s_tready_back"}, 32'(s_tready), 32'd1);
        check({nm, "_hit_pulses"}, 32'(pulse_cnt - p0), 32'(pulses));
    endtask

    initial begin
        logic [31:0] exp_cnt;
        int          n;
        logic        ok;

        rst_n    = 1'b0;
        target   = '0;
        s_tdata  = '0;
        s_tstrb  = 4'h0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;

        vecs[0] = '{dig: 256'd0, tgt: 256'd1, nw: 8, tl: 1'b1, st: 32'h1, cyc: 8};
        vecs[1] = '{dig: {8{32'hDEADBEEF}}, tgt: {8{32'hDEADBEEF}}, nw: 8, tl: 1'b1, st: 32'h1, cyc: 8};
        vecs[2] = '{dig: {{7{32'hDEADBEEF}}, 32'hDEADBEF0}, tgt: {8{32'hDEADBEEF}},
                    nw: 8, tl: 1'b1, st: 32'h0, cyc: 8};
        vecs[3] = '{dig: {32'hFFFFFFFF, 224'd0}, tgt: {32'h0000FFFF, 224'd0},
                    nw: 8, tl: 1'b1, st: 32'h0, cyc: 1};
        vecs[4] = '{dig: 256'd0, tgt: 256'd0, nw: 8, tl: 1'b0, st: 32'h5, cyc: 8};
        vecs[5] = '{dig: {{3{32'h11111111}}, 32'h10000000, 32'h1, 32'h2, 32'h3, 32'h4},
                    tgt: {{3{32'h11111111}}, 32'h20000000, {4{32'hFFFFFFFF}}},
                    nw: 8, tl: 1'b1, st: 32'h1, cyc: 4};

        repeat (3) @(negedge clk);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tdata", m_tdata, 32'd0);
        check("rst_m_tlast", 32'(m_tlast), 32'd0);
        check("rst_hit_pulse", 32'(hit_pulse), 32'd0);
        check("m_tstrb", 32'(m_tstrb), 32'hF);
        rst_n = 1'b1;
        @(negedge clk);
        check("s_tready_after_release", 32'(s_tready), 32'd1);

        exp_cnt = 32'd0;
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].dig, vecs[i].tgt, vecs[i].nw, vecs[i].tl);
            exp_cnt = exp_cnt + 32'd1;
            check_out($sformatf("vec%0d", i), vecs[i].st, exp_cnt, vecs[i].cyc,
                      int'(vecs[i].st[0]), 0);
        end

        // Short frame, then a clean full frame; count restarts from reset.
        do_reset();
        send_frame({8{32'hA5A5A5A5}}, 256'd0, 4, 1'b1);
        check_out("short", 32'h2, 32'd1, 1, 0, 0);
        send_frame(256'd0, {256{1'b1}}, 8, 1'b1);
        check_out("after_short", 32'h1, 32'd2, 1, 1, 0);

        send_frame(256'd0, 256'd1, 8, 1'b1);
        check_out("backpressure", 32'h1, 32'd3, 8, 1, 10);

        // Reset in the middle of a frame.
        for (int i = 0; i < 5; i++) put_beat(32'(i + 1), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midframe_rst_s_tready", 32'(s_tready), 32'd0);
        check("midframe_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_frame(256'd0, 256'd1, 8, 1'b1);
        check_out("after_midframe_rst", 32'h1, 32'd1, 8, 1, 0);

        // Reset while the status beat is stalled.
        m_tready = 1'b0;
        send_frame(256'd0, 256'd1, 8, 1'b1);
        n = 0;
        while (m_tvalid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("midsend_tvalid_seen", 32'(m_tvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midsend_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("midsend_rst_m_tdata", m_tdata, 32'd0);
        check("midsend_rst_m_tlast", 32'(m_tlast), 32'd0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        m_tready = 1'b1;
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            ok = ok && (m_tvalid === 1'b0);
        end
        check("midsend_no_partial_output", 32'(ok), 32'd1);
        send_frame(256'd0, 256'd1, 8, 1'b1);
        check_out("after_midsend_rst", 32'h1, 32'd1, 8, 1, 0);

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule

// File: doc/axis_hash_check.md
AXIS_HASH_CHECK -- requirements
Module: axis_hash_check

Interface
REQ-001 SHALL have parameter C_S_AXIS_TDATA_WIDTH, default 32, slave data width; only 32 is supported.
REQ-002 SHALL have parameter C_M_AXIS_TDATA_WIDTH, default 32, master data width; only 32 is supported.
REQ-003 SHALL have parameter NUMBER_OF_HASH_WORDS, default 8, digest words per frame.
REQ-004 SHALL have port s00_axis_aclk, input, 1 bit: the single clock for both AXIS sides.
REQ-005 SHALL have port s00_axis_aresetn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port target, input, 256 bits: difficulty target, bit 255 is MSB.
REQ-007 SHALL have slave ports s00_axis_tready (out, 1), s00_axis_tdata (in, 32), s00_axis_tstrb (in, 4, ignored), s00_axis_tlast (in, 1) and s00_axis_tvalid (in, 1).
REQ-008 SHALL have master ports m00_axis_tvalid (out, 1), m00_axis_tdata (out, 32), m00_axis_tstrb (out, 4, constant all ones), m00_axis_tlast (out, 1) and m00_axis_tready (in, 1).
REQ-009 SHALL have port hit_pulse, output, 1 bit: one-cycle pulse on each qualifying digest.

Function
REQ-010 SHALL implement FSM states RECV, COMPARE and SEND, and SHALL enter RECV from reset.
REQ-011 In RECV, s00_axis_tready SHALL be 1; it SHALL be 0 in all other states.
REQ-012 SHALL store each accepted beat (tvalid && tready) at word index wr_idx, starting at 0 and incrementing by 1 per beat.
REQ-013 SHALL register target on the beat where wr_idx==0; later changes to target SHALL NOT affect the frame in flight.
REQ-014 A frame SHALL end on whichever comes first: a beat with tlast=1, or the beat with wr_idx==7.
REQ-015 On frame end, the FSM SHALL go RECV->COMPARE on the next cycle and SHALL reset wr_idx to 0.
REQ-016 SHALL flag short=1 if tlast arrives with wr_idx<7.
REQ-017 SHALL flag notlast=1 if wr_idx==7 arrives with tlast=0; the next beat SHALL then start a new frame.
REQ-018 The digest value SHALL be {word7,...,word0}, with word 7 most significant.
REQ-019 COMPARE SHALL examine one word per cycle, from word 7 down to word 0, against the matching 32-bit slice of the registered target.
REQ-020 COMPARE SHALL exit on the first unequal word: hit=1 if digest word < target slice, else hit=0.
REQ-021 If all 8 words are equal, COMPARE SHALL set hit=1 (hit means digest <= target), with a worst-case latency of 8 cycles.
REQ-022 If short=1, COMPARE SHALL last exactly 1 cycle and SHALL force hit=0.
REQ-023 On leaving COMPARE, digest_cnt (32-bit) SHALL increment, wrapping from 0xFFFFFFFF to 0.
REQ-024 On leaving COMPARE, hit_pulse SHALL be 1 for exactly that cycle if hit=1.
REQ-025 SEND SHALL emit exactly 2 beats with m00_axis_tvalid=1: beat 0 = {29'b0, notlast, short, hit}, beat 1 = digest_cnt including the current frame.
REQ-026 m00_axis_tlast SHALL be 1 only on beat 1.
REQ-027 m00_axis_tdata SHALL hold stable while tvalid=1 and tready=0.
REQ-028 A beat SHALL advance only on m00_axis_tvalid && m00_axis_tready.
REQ-029 After beat 1 is accepted, the FSM SHALL return to RECV on the next cycle and clear the short, notlast and hit flags.
REQ-030 m00_axis_tvalid SHALL NOT depend combinationally on m00_axis_tready.
REQ-031 Slave input SHALL be back-pressured (tready=0) throughout COMPARE and SEND; no beats SHALL be dropped.

Reset
REQ-032 While s00_axis_aresetn=0: state=RECV, wr_idx=0, digest_cnt=0, flags=0, m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0, hit_pulse=0, and s00_axis_tready SHALL be 0.
REQ-033 Reset asserted mid-frame or mid-SEND SHALL abandon the frame; no partial output SHALL appear after release.
REQ-034 s00_axis_tready SHALL rise on the first clock edge after reset deasserts.

Structure
REQ-035 The shared sha package SHALL hold the state encodings, NUMBER_OF_HASH_WORDS and the status bit positions (HIT=0, SHORT=1, NOTLAST=2).
REQ-036 The word-serial 256-bit magnitude comparator SHALL be a single sub-module named hash_cmp_serial, with inputs start/digest/target and outputs done/hit.
REQ-037 The digest buffer SHALL be a register array in the top module; no FIFO IP SHALL be used.

Verification
REQ-038 Test 1: digest words 0..7 = 0, target = 1, tlast on word 7 -> beats 0x00000001, 0x00000001; hit_pulse seen once.
REQ-039 Test 2: digest = target exactly (all 0xDEADBEEF) -> hit=1 after 8 COMPARE cycles; digest = target+1 in word 0 -> hit=0.
REQ-040 Test 3: word7 = 0xFFFFFFFF, target[255:224] = 0x0000FFFF -> hit=0 with a 1-cycle COMPARE; status = 0x00000000.
REQ-041 Test 4: tlast on word 3 -> status = 0x00000002; the next 8-word frame is accepted cleanly and reports count 2.
REQ-042 Test 5: m00_axis_tready held low for 10 cycles in SEND -> tdata and tvalid stay stable, s00_axis_tready=0, and there is no data loss.
REQ-043 Test 6: aresetn pulsed low at word 5 -> outputs go to 0 immediately; after release a full frame reports count 1.
